// File: rtl/i2c_slave_ptr_reg.sv
// I2C target with a 16-bit register pointer: write pointer then data, or read from pointer.
// SCL/SDA are oversampled on PT_CK; a single-cycle register port faces the fabric.
module i2c_slave_ptr_reg #(
   parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
   input  logic        PT_CK,
   input  logic        RESET,
   input  logic        SCLI,
   input  logic        SDAI,
   output logic        SDA_OE,
   output logic [15:0] REG_ADDR,
   output logic [7:0]  REG_WDATA,
   output logic        REG_WR,
   output logic        REG_RD,
   input  logic [7:0]  REG_RDATA,
   output logic        BUSY,
   output logic [3:0]  ST
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ADDR      = 4'd1,
      S_ADDR_ACK  = 4'd2,
      S_PTR_H     = 4'd3,
      S_PTR_H_ACK = 4'd4,
      S_PTR_L     = 4'd5,
      S_PTR_L_ACK = 4'd6,
      S_WDATA     = 4'd7,
      S_WDATA_ACK = 4'd8,
      S_RDATA     = 4'd9,
      S_RDATA_ACK = 4'd10,
      S_WAIT      = 4'd11
   } state_t;

   logic        r_scl_s1, r_scl_s2, r_scl_h;
   logic        r_sda_s1, r_sda_s2, r_sda_h;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [7:0]  r_sr;
   logic        r_rw;
   logic        r_oe;
   logic        r_busy;
   logic        r_wr;
   logic        r_rd;
   logic        r_cap;
   logic        r_inc;
   logic [15:0] r_ptr;
   logic [7:0]  r_wdata;

   logic        w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0]  w_byte;

   // Synchronizers reset to the idle-bus level so no false event fires after reset
   always_ff @(posedge PT_CK or posedge RESET) begin
      if (RESET) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_h  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_h  <= 1'b1;
      end else begin
         r_scl_s1 <= SCLI;
         r_scl_s2 <= r_scl_s1;
         r_scl_h  <= r_scl_s2;
         r_sda_s1 <= SDAI;
         r_sda_s2 <= r_sda_s1;
         r_sda_h  <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_h;
   assign w_scl_fall = ~r_scl_s2 & r_scl_h;
   assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
   assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
   assign w_byte     = {r_sr[6:0], r_sda_s2};

   always_ff @(posedge PT_CK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_sr    <= 8'd0;
         r_rw    <= 1'b0;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_cap   <= 1'b0;
         r_inc   <= 1'b0;
         r_ptr   <= 16'd0;
         r_wdata <= 8'd0;
      end else begin
         // Read pipeline: strobe, capture one cycle later, then bump the pointer
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_cap <= r_rd;
         r_inc <= r_cap;
         if (r_cap)
            r_sr <= REG_RDATA;
         if (r_wr || r_inc)
            r_ptr <= r_ptr + 16'd1;

         if (w_start) begin
            r_state <= S_ADDR;
            r_cnt   <= 4'd0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
         end else if (w_stop) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise && r_cnt != 4'd8) begin
                     r_sr  <= w_byte;
                     r_cnt <= r_cnt + 4'd1;
                     if (r_cnt == 4'd7) begin
                        r_rw <= r_sda_s2;
                        if (w_byte[7:1] != SLAVE_ADDR)
                           r_state <= S_WAIT;
                     end
                  end else if (w_scl_fall && r_cnt == 4'd8) begin
                     r_oe    <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= S_ADDR_ACK;
                  end
               end
               S_ADDR_ACK: begin
                  if (w_scl_rise && r_rw)
                     r_rd <= 1'b1;
                  else if (w_scl_fall) begin
                     r_cnt <= 4'd0;
                     if (r_rw) begin
                        r_oe    <= ~r_sr[7];
                        r_sr    <= {r_sr[6:0], 1'b0};
                        r_state <= S_RDATA;
                     end else begin
                        r_oe    <= 1'b0;
                        r_state <= S_PTR_H;
                     end
                  end
               end
               S_PTR_H, S_PTR_L, S_WDATA: begin
                  if (w_scl_rise && r_cnt != 4'd8) begin
                     r_sr  <= w_byte;
                     r_cnt <= r_cnt + 4'd1;
                     if (r_cnt == 4'd7) begin
                        if (r_state == S_PTR_H)
                           r_ptr[15:8] <= w_byte;
                        else if (r_state == S_PTR_L)
                           r_ptr[7:0] <= w_byte;
                        else begin
                           r_wr    <= 1'b1;
                           r_wdata <= w_byte;
                        end
                     end
                  end else if (w_scl_fall && r_cnt == 4'd8) begin
                     r_oe <= 1'b1;
                     if (r_state == S_PTR_H)
                        r_state <= S_PTR_H_ACK;
                     else if (r_state == S_PTR_L)
                        r_state <= S_PTR_L_ACK;
                     else
                        r_state <= S_WDATA_ACK;
                  end
               end
               S_PTR_H_ACK, S_PTR_L_ACK, S_WDATA_ACK: begin
                  if (w_scl_fall) begin
                     r_oe  <= 1'b0;
                     r_cnt <= 4'd0;
                     r_state <= (r_state == S_PTR_H_ACK) ? S_PTR_L : S_WDATA;
                  end
               end
               S_RDATA: begin
                  if (w_scl_rise)
                     r_cnt <= r_cnt + 4'd1;
                  else if (w_scl_fall) begin
                     if (r_cnt == 4'd8) begin
                        r_oe    <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_state <= S_RDATA_ACK;
                     end else begin
                        r_oe <= ~r_sr[7];
                        r_sr <= {r_sr[6:0], 1'b0};
                     end
                  end
               end
               S_RDATA_ACK: begin
                  // Any fall seen here follows an ACK; a NACK has already left for WAIT
                  if (w_scl_rise) begin
                     if (!r_sda_s2)
                        r_rd <= 1'b1;
                     else
                        r_state <= S_WAIT;
                  end else if (w_scl_fall) begin
                     r_oe    <= ~r_sr[7];
                     r_sr    <= {r_sr[6:0], 1'b0};
                     r_cnt   <= 4'd0;
                     r_state <= S_RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign SDA_OE    = r_oe;
   assign REG_ADDR  = r_ptr;
   assign REG_WDATA = r_wdata;
   assign REG_WR    = r_wr;
   assign REG_RD    = r_rd;
   assign BUSY      = r_busy;
   assign ST        = r_state;

endmodule

// File: tb/tb_i2c_slave_ptr_reg.sv
// Bench for i2c_slave_ptr_reg: bit-banged I2C initiator, strobe scoreboard and inline bus checks.
module tb_i2c_slave_ptr_reg;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        m_scl = 1'b1;
   logic        m_sda = 1'b1;
   logic        SDAI;
   logic        SDA_OE;
   logic [15:0] REG_ADDR;
   logic [7:0]  REG_WDATA;
   logic        REG_WR;
   logic        REG_RD;
   logic [7:0]  REG_RDATA;
   logic        BUSY;
   logic [3:0]  ST;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   oe_hi_cnt = 0;
   int   busy_hi_cnt = 0;

   always #5 clk = ~clk;

   // Open-drain bus: the line is low if either side pulls it
   assign SDAI      = m_sda & ~SDA_OE;
   assign REG_RDATA = ~REG_ADDR[7:0];

   i2c_slave_ptr_reg #(.SLAVE_ADDR(7'h10)) dut (
      .PT_CK     (clk),
      .RESET     (RESET),
      .SCLI      (m_scl),
      .SDAI      (SDAI),
      .SDA_OE    (SDA_OE),
      .REG_ADDR  (REG_ADDR),
      .REG_WDATA (REG_WDATA),
      .REG_WR    (REG_WR),
      .REG_RD    (REG_RD),
      .REG_RDATA (REG_RDATA),
      .BUSY      (BUSY),
      .ST        (ST)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the next expected entry
   always @(negedge clk) begin
      if (SDA_OE) oe_hi_cnt++;
      if (BUSY) busy_hi_cnt++;
      if (!RESET && (REG_WR || REG_RD)) begin
         check("strobe_excl", {31'd0, REG_WR & REG_RD}, 32'd0);
         check("strobe_busy", {31'd0, BUSY}, 32'd1);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=%0h, expected no strobe", REG_WR, REG_RD, REG_ADDR);
         end else begin
            m_e = exp_q.pop_front();
            check("strobe_kind", {31'd0, REG_WR}, {31'd0, m_e.wr});
            check("strobe_addr", {16'd0, REG_ADDR}, {16'd0, m_e.addr});
            if (m_e.wr)
               check("strobe_wdata", {24'd0, REG_WDATA}, {24'd0, m_e.data});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic wr, input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      e.wr = wr; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   // One bit: data set mid-low, SCL high 20 cycles, bus sampled mid-high
   task automatic bit_x(input logic b, output logic s);
      m_sda = b;
      cyc(10);
      m_scl = 1'b1;
      cyc(10);
      s = SDAI;
      cyc(10);
      m_scl = 1'b0;
      cyc(10);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      cyc(10);
      m_scl = 1'b1;
      cyc(20);
      m_sda = 1'b0;
      cyc(20);
      m_scl = 1'b0;
      cyc(10);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      cyc(10);
      m_scl = 1'b1;
      cyc(20);
      m_sda = 1'b1;
      cyc(20);
   endtask

   task automatic wr_byte(input logic [7:0] v, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_x(v[i], s);
      bit_x(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, s);
         v[i] = s;
      end
      bit_x(nack, s);
   endtask

   task automatic wr_acked(input string name, input logic [7:0] v);
      logic ack;
      wr_byte(v, ack);
      check(name, {31'd0, ack}, 32'd0);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rv;
      int         oe0, busy0;

      cyc(4);
      check("rst_sda_oe", {31'd0, SDA_OE}, 32'd0);
      check("rst_st", {28'd0, ST}, 32'd0);
      RESET = 1'b0;
      cyc(4);
      check("rst_outputs", {REG_ADDR, REG_WDATA, 1'b0, REG_WR, REG_RD, BUSY, ST},
            {16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});

      // Pointer write then two data writes
      push_exp(1'b1, 16'h1234, 8'hAB);
      push_exp(1'b1, 16'h1235, 8'hCD);
      i2c_start();
      wr_acked("wr_addr_ack", 8'h20);
      check("wr_busy", {31'd0, BUSY}, 32'd1);
      wr_acked("wr_ptrh_ack", 8'h12);
      wr_acked("wr_ptrl_ack", 8'h34);
      wr_acked("wr_d0_ack", 8'hAB);
      wr_acked("wr_d1_ack", 8'hCD);
      i2c_stop();
      check("wr_ptr_after", {16'd0, REG_ADDR}, 32'h1236);
      check("wr_busy_after", {31'd0, BUSY}, 32'd0);
      check("wr_idle", {28'd0, ST}, 32'd0);

      // Pointer set, repeated start, read two bytes (ACK then NACK)
      push_exp(1'b0, 16'h00FF, 8'h00);
      push_exp(1'b0, 16'h0100, 8'h00);
      i2c_start();
      wr_acked("rd_addrw_ack", 8'h20);
      wr_acked("rd_ptrh_ack", 8'h00);
      wr_acked("rd_ptrl_ack", 8'hFF);
      i2c_start();
      wr_acked("rd_addrr_ack", 8'h21);
      rd_byte(1'b0, rv);
      check("rd_byte0", {24'd0, rv}, 32'h00);
      rd_byte(1'b1, rv);
      check("rd_byte1", {24'd0, rv}, 32'hFF);
      cyc(5);
      check("rd_released", {31'd0, SDA_OE}, 32'd0);
      i2c_stop();
      check("rd_ptr_after", {16'd0, REG_ADDR}, 32'h0101);

      // Pointer wrap
      push_exp(1'b1, 16'hFFFF, 8'h11);
      push_exp(1'b1, 16'h0000, 8'h22);
      i2c_start();
      wr_acked("wrap_addr_ack", 8'h20);
      wr_acked("wrap_ptrh_ack", 8'hFF);
      wr_acked("wrap_ptrl_ack", 8'hFF);
      wr_acked("wrap_d0_ack", 8'h11);
      wr_acked("wrap_d1_ack", 8'h22);
      i2c_stop();
      check("wrap_ptr_after", {16'd0, REG_ADDR}, 32'h0001);

      // Address mismatch: bus never driven, never busy
      oe0 = oe_hi_cnt;
      busy0 = busy_hi_cnt;
      i2c_start();
      wr_byte(8'h22, ack);
      check("nm_addr_nack", {31'd0, ack}, 32'd1);
      wr_byte(8'h55, ack);
      check("nm_data_nack", {31'd0, ack}, 32'd1);
      i2c_stop();
      check("nm_oe_never", oe_hi_cnt - oe0, 32'd0);
      check("nm_busy_never", busy_hi_cnt - busy0, 32'd0);
      check("nm_ptr", {16'd0, REG_ADDR}, 32'h0001);

      // Abort mid-byte with a repeated start
      i2c_start();
      wr_acked("ab_addr_ack", 8'h20);
      wr_acked("ab_ptrh_ack", 8'h12);
      bit_x(1'b1, s);
      bit_x(1'b0, s);
      bit_x(1'b1, s);
      bit_x(1'b0, s);
      i2c_start();
      check("ab_state", {28'd0, ST}, 32'd1);
      check("ab_ptr", {16'd0, REG_ADDR}, 32'h1201);
      check("ab_busy", {31'd0, BUSY}, 32'd0);
      i2c_stop();

      // Reset while the target drives a read data bit
      push_exp(1'b0, 16'h0080, 8'h00);
      i2c_start();
      wr_acked("rr_addrw_ack", 8'h20);
      wr_acked("rr_ptrh_ack", 8'h00);
      wr_acked("rr_ptrl_ack", 8'h80);
      i2c_start();
      wr_acked("rr_addrr_ack", 8'h21);
      check("rr_bit7_drive", {31'd0, SDA_OE}, 32'd1);
      #3;
      RESET = 1'b1;
      #1;
      check("rr_oe_async", {31'd0, SDA_OE}, 32'd0);
      m_scl = 1'b1;
      m_sda = 1'b1;
      cyc(3);
      check("rr_outputs", {REG_ADDR, REG_WDATA, 1'b0, REG_WR, REG_RD, BUSY, ST},
            {16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      RESET = 1'b0;
      cyc(20);

      check("pending_strobes", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
